// File: rtl/wb_master.sv
// wb_master: single-outstanding Wishbone classic initiator.
// A valid/ready command becomes one WB read or write cycle. The result comes back
// on a one-cycle response strobe. A cycle with no ack/err is aborted after TIMEOUT
// cycles, and the abort is reported as an error.
module wb_master #(
   parameter int unsigned WORD    = 16,
   parameter int unsigned ADDR    = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_we_i,
   input  logic [ADDR-1:0]     cmd_addr_i,
   input  logic [WORD/8-1:0]   cmd_sel_i,
   input  logic [WORD-1:0]     cmd_dat_i,
   output logic                rsp_valid_o,
   output logic                rsp_err_o,
   output logic [WORD-1:0]     rsp_dat_o,
   output logic                cyc_o,
   output logic                stb_o,
   output logic                we_o,
   output logic [ADDR-1:0]     adr_o,
   output logic [WORD/8-1:0]   sel_o,
   output logic [WORD-1:0]     dat_o,
   input  logic [WORD-1:0]     dat_i,
   input  logic                ack_i,
   input  logic                err_i
);

   localparam int unsigned SEL = WORD / 8;
   localparam int unsigned CW  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              cyc_q, cyc_d;
   logic              we_q, we_d;
   logic [ADDR-1:0]   adr_q, adr_d;
   logic [SEL-1:0]    sel_q, sel_d;
   logic [WORD-1:0]   wdat_q, wdat_d;
   logic              rvalid_q, rvalid_d;
   logic              rerr_q, rerr_d;
   logic [WORD-1:0]   rdat_q, rdat_d;

   logic [CW-1:0]     cnt_next;
   logic              timeout_hit;
   logic              bus_done;

   // The counter saturates instead of wrapping, so TIMEOUT=0 can never abort.
   assign cnt_next    = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
   assign timeout_hit = (TIMEOUT != 0) && (cnt_next == TO_LIMIT);
   assign bus_done    = err_i || ack_i || timeout_hit;

   // State register and registered outputs; async active-low reset drops any transfer.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         sel_q    <= '0;
         wdat_q   <= '0;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
         rdat_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         sel_q    <= sel_d;
         wdat_q   <= wdat_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
         rdat_q   <= rdat_d;
      end
   end

   // Next-state logic: IDLE -> BUS on a command, BUS -> RESP on ack/err/timeout, RESP -> IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cmd_valid_i) state_d = BUS;
         BUS:     if (bus_done)    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values for the registered outputs. err_i takes priority over ack_i,
   // and ack_i takes priority over an expiring timeout.
   always_comb begin
      cnt_d    = cnt_q;
      cyc_d    = cyc_q;
      we_d     = we_q;
      adr_d    = adr_q;
      sel_d    = sel_q;
      wdat_d   = wdat_q;
      rvalid_d = 1'b0;
      rerr_d   = rerr_q;
      rdat_d   = rdat_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               we_d   = cmd_we_i;
               adr_d  = cmd_addr_i;
               sel_d  = cmd_sel_i;
               wdat_d = cmd_dat_i;
               cyc_d  = 1'b1;
               cnt_d  = '0;
            end
         end
         BUS: begin
            if (err_i) begin
               rerr_d = 1'b1;
            end else if (ack_i) begin
               rerr_d = 1'b0;
               if (!we_q) rdat_d = dat_i;
            end else begin
               cnt_d = cnt_next;
               if (timeout_hit) rerr_d = 1'b1;
            end
            if (bus_done) begin
               cyc_d    = 1'b0;
               we_d     = 1'b0;
               rvalid_d = 1'b1;
            end
         end
         RESP:    ;
         default: ;
      endcase
   end

   assign cmd_ready_o = (state_q == IDLE);
   assign cyc_o       = cyc_q;
   assign stb_o       = cyc_q;
   assign we_o        = we_q;
   assign adr_o       = adr_q;
   assign sel_o       = sel_q;
   assign dat_o       = wdat_q;
   assign rsp_valid_o = rvalid_q;
   assign rsp_err_o   = rerr_q;
   assign rsp_dat_o   = rdat_q;

endmodule
